// File: rtl/instr_loader.sv
// instr_loader: encodes field-level instructions into 32-bit TessiaV1 words
// and streams them into instruction memory from address 0.
module instr_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [3:0]        in_cond,
    input  logic [2:0]        in_aluop,
    input  logic              in_s,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    wc_q, wc_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;

    logic                legal;
    logic [31:0]         enc_word;
    logic [3:0]          cmd;
    logic                s_bit;
    logic [3:0]          rd_f;
    logic [3:0]          rn_f;
    logic [11:0]         src2;
    logic                accept;
    logic                at_top;

    // Field-to-word encoder and legality check
    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        cmd      = '0;
        s_bit    = 1'b0;
        rd_f     = '0;
        rn_f     = '0;
        src2     = '0;
        case (in_class)
            3'd0, 3'd1: begin
                case (in_aluop)
                    3'd0:    cmd = 4'b0100;
                    3'd1:    cmd = 4'b0010;
                    3'd2:    cmd = 4'b0000;
                    3'd3:    cmd = 4'b1100;
                    3'd4:    cmd = 4'b1101;
                    3'd5:    cmd = 4'b1010;
                    default: legal = 1'b0;
                endcase
                // CMP always sets flags and has no destination; MOV has no first operand
                s_bit    = in_s | (in_aluop == 3'd5);
                rd_f     = (in_aluop == 3'd5) ? 4'd0 : in_rd;
                rn_f     = (in_aluop == 3'd4) ? 4'd0 : in_rn;
                src2     = in_class[0] ? in_imm[11:0] : {8'd0, in_rm};
                enc_word = {in_cond, 2'b00, in_class[0], cmd, s_bit, rn_f, rd_f, src2};
            end
            3'd2, 3'd3: enc_word = {in_cond, 2'b01, 5'b01100, ~in_class[0], in_rn, in_rd, in_imm[11:0]};
            3'd4:       enc_word = {in_cond, 4'b1010, in_imm};
            default:    legal = 1'b0;
        endcase
    end

    assign in_ready = (state_q == S_LOAD) & ~start;
    assign accept   = in_valid & in_ready;
    assign at_top   = (ptr_q == {ADDR_W{1'b1}});

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wc_d    = wc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            wc_d    = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_word;
                ptr_d   = ptr_q + ADDR_W'(1);
                wc_d    = wc_q + CNT_W'(1);
                if (at_top) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!in_last) begin
                        err_d = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
            if (in_last) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader (ADDR_W=2): directed encodings, overflow, illegal
// entries, restart and reset, then randomized traffic against a reference model.
module tb_instr_loader;

    localparam int unsigned ADDR_W = 2;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [3:0]        in_cond;
    logic [2:0]        in_aluop;
    logic              in_s;
    logic [3:0]        in_rd;
    logic [3:0]        in_rn;
    logic [3:0]        in_rm;
    logic [23:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_class(in_class), .in_cond(in_cond),
        .in_aluop(in_aluop), .in_s(in_s), .in_rd(in_rd), .in_rn(in_rn),
        .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err(err), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_load = 0;
    int m_ptr  = 0;
    int m_wc   = 0;
    bit m_err  = 0;

    int cmd_tab [6] = '{4, 2, 0, 12, 13, 10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_f(input logic [2:0] c, input logic [2:0] a);
        if (c > 3'd4) return 0;
        if (c <= 3'd1 && a >= 3'd6) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] enc_f(input logic [2:0] c, input logic [3:0] cond,
                                          input logic [2:0] a, input logic s, input logic [3:0] rd,
                                          input logic [3:0] rn, input logic [3:0] rm,
                                          input logic [23:0] imm);
        int w;
        int sflag, rdv, rnv, src;
        w = int'(cond) * (1 << 28);
        if (c <= 3'd1) begin
            sflag = (a == 3'd5) ? 1 : int'(s);
            rdv   = (a == 3'd5) ? 0 : int'(rd);
            rnv   = (a == 3'd4) ? 0 : int'(rn);
            src   = (c == 3'd1) ? int'(imm[11:0]) : int'(rm);
            w += int'(c) * (1 << 25) + cmd_tab[a] * (1 << 21) + sflag * (1 << 20)
               + rnv * (1 << 16) + rdv * (1 << 12) + src;
        end else if (c <= 3'd3) begin
            w += (1 << 26) + 12 * (1 << 21) + ((c == 3'd2) ? (1 << 20) : 0)
               + int'(rn) * (1 << 16) + int'(rd) * (1 << 12) + int'(imm[11:0]);
        end else begin
            w += (2 << 26) + (2 << 24) + int'(imm);
        end
        return 32'(w);
    endfunction

    // one clock: check in_ready, advance the model, check registered outputs
    task automatic step();
        bit nwe, ndone, term;
        logic [31:0] ndata;
        int naddr;
        #1;
        check("in_ready", 32'(in_ready), 32'(m_load && !start));
        nwe = 0; ndone = 0; ndata = 0; naddr = 0;
        if (start) begin
            m_load = 1; m_ptr = 0; m_wc = 0; m_err = 0;
        end else if (in_valid && m_load) begin
            term = in_last;
            if (legal_f(in_class, in_aluop)) begin
                nwe = 1; naddr = m_ptr;
                ndata = enc_f(in_class, in_cond, in_aluop, in_s, in_rd, in_rn, in_rm, in_imm);
                if (m_ptr == DEPTH - 1) begin
                    term = 1;
                    if (!in_last) m_err = 1;
                end
                m_ptr = (m_ptr + 1) % DEPTH;
                m_wc++;
            end else begin
                m_err = 1;
            end
            if (term) m_load = 0;
            ndone = term;
        end
        @(posedge clk);
        @(negedge clk);
        check("mem_we", 32'(mem_we), 32'(nwe));
        check("done", 32'(done), 32'(ndone));
        check("err", 32'(err), 32'(m_err));
        check("word_count", 32'(word_count), 32'(m_wc));
        check("busy", 32'(busy), 32'(m_load));
        if (nwe) begin
            check("mem_addr", 32'(mem_addr), 32'(naddr));
            check("mem_wdata", mem_wdata, ndata);
        end
    endtask

    task automatic do_start();
        start = 1; in_valid = 0;
        step();
        start = 0;
    endtask

    task automatic send(input logic [2:0] c, input logic [3:0] cond, input logic [2:0] a,
                        input logic s, input logic [3:0] rd, input logic [3:0] rn,
                        input logic [3:0] rm, input logic [23:0] imm, input logic last);
        in_valid = 1; in_class = c; in_cond = cond; in_aluop = a; in_s = s;
        in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
        step();
        in_valid = 0; in_last = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_wc"}, 32'(word_count), 0);
        check({tag, "_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        reset = 0; start = 0; in_valid = 0; in_class = 0; in_cond = 0; in_aluop = 0;
        in_s = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0; in_last = 0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1;

        // ADD r1, r2, r3 as a one-word program
        do_start();
        send(3'd0, 4'hE, 3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0, 1'b1);
        check("add_word", mem_wdata, 32'hE0821003);
        check("add_done", 32'(done), 1);
        check("add_wc", 32'(word_count), 1);

        // CMP forces S and Rd; then LDR, STR, B
        do_start();
        send(3'd0, 4'hE, 3'd5, 1'b0, 4'd9, 4'd4, 4'd5, 24'h0, 1'b0);
        check("cmp_word", mem_wdata, 32'hE1540005);
        send(3'd2, 4'hE, 3'd0, 1'b0, 4'd1, 4'd0, 4'd0, 24'h000004, 1'b0);
        check("ldr_word", mem_wdata, 32'hE5901004);
        send(3'd3, 4'hE, 3'd0, 1'b0, 4'd1, 4'd0, 4'd0, 24'h000004, 1'b1);
        check("str_word", mem_wdata, 32'hE5801004);
        check("str_addr", 32'(mem_addr), 2);
        do_start();
        send(3'd4, 4'hE, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1);
        check("b_word", mem_wdata, 32'hEAFFFFFE);

        // overflow: four legal words with no last
        do_start();
        for (int i = 0; i < 4; i++)
            send(3'd1, 4'h0, 3'(i), 1'b1, 4'(i), 4'(i + 1), 4'd0, 24'(i * 17), 1'b0);
        check("ovf_addr", 32'(mem_addr), 3);
        check("ovf_done", 32'(done), 1);
        check("ovf_err", 32'(err), 1);
        check("ovf_wc", 32'(word_count), 4);
        send(3'd0, 4'hE, 3'd0, 1'b0, 4'd1, 4'd1, 4'd1, 24'h0, 1'b0);

        // illegal entry between two legal words, then restart with a write pending
        do_start();
        send(3'd0, 4'h1, 3'd3, 1'b0, 4'd7, 4'd6, 4'd5, 24'h0, 1'b0);
        send(3'd5, 4'h1, 3'd0, 1'b0, 4'd7, 4'd6, 4'd5, 24'h0, 1'b0);
        check("ill_err", 32'(err), 1);
        check("ill_we", 32'(mem_we), 0);
        send(3'd0, 4'h1, 3'd6, 1'b0, 4'd7, 4'd6, 4'd5, 24'h0, 1'b0);
        send(3'd4, 4'h2, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h123456, 1'b0);
        check("ill_addr", 32'(mem_addr), 1);
        start = 1;
        #1;
        check("pend_we", 32'(mem_we), 1);
        check("pend_addr", 32'(mem_addr), 1);
        check("pend_data", mem_wdata, 32'h2A123456);
        step();
        start = 0;
        check("restart_err", 32'(err), 0);
        check("restart_wc", 32'(word_count), 0);

        // asynchronous reset with a write pending
        send(3'd0, 4'hE, 3'd1, 1'b1, 4'd2, 4'd3, 4'd4, 24'h0, 1'b0);
        #2;
        reset = 0;
        #1;
        check_all_zero("async_rst");
        m_load = 0; m_ptr = 0; m_wc = 0; m_err = 0;
        @(negedge clk);
        reset = 1;
        send(3'd0, 4'hE, 3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_class = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            in_aluop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_cond  = 4'($urandom);
            in_s     = 1'($urandom);
            in_rd    = 4'($urandom);
            in_rn    = 4'($urandom);
            in_rm    = 4'($urandom);
            in_imm   = 24'($urandom);
            in_last  = ($urandom_range(0, 4) == 0);
            step();
        end
        start = 0; in_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Streams symbolic instructions from a host or test sequencer into TessiaV1 instruction memory. Each field-level instruction is encoded into the 32-bit word format that the core's instruction decoder consumes: cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], src2[11:0]. Words are written to consecutive addresses starting at 0. The block sits between the program source and the instruction-memory write port and is idle once the core runs.

## Interface
- ADDR_W, 6, instruction-memory address width; capacity DEPTH = 2**ADDR_W words
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a new load at address 0
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader accepts fields this cycle
- in_class  in  3  0 DP-reg, 1 DP-imm, 2 LDR, 3 STR, 4 B, 5-7 illegal
- in_cond  in  4  condition field
- in_aluop  in  3  0 ADD, 1 SUB, 2 MUL, 3 ORR, 4 MOV, 5 CMP, 6-7 illegal (DP classes only)
- in_s  in  1  set-flags bit (DP only)
- in_rd, in_rn, in_rm  in  4 each  register fields
- in_imm  in  24  immediate; [11:0] for DP-imm/LDR/STR, [23:0] for B
- in_last  in  1  final instruction of program
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded word
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse, load finished
- err  out  1  sticky; illegal entry or overflow; cleared by start
- word_count  out  ADDR_W+1  legal words accepted since start

## Operation
- FSM states:
  - IDLE: IDLE->LOAD on start.
  - LOAD: LOAD->IDLE on acceptance with in_last=1, or on a legal acceptance into address DEPTH-1. start in LOAD restarts the load.
- in_ready = (state==LOAD) & ~start. Acceptance = in_valid & in_ready.
- DP encoding:
  - op=00, funct={I, cmd[3:0], S}. I=1 for DP-imm (src2=in_imm[11:0]). I=0 for DP-reg (src2={8'b0, in_rm}).
  - cmd: ADD 0100, SUB 0010, MUL 0000, ORR 1100, MOV 1101, CMP 1010.
  - CMP forces S=1 and Rd=0. MOV forces Rn=0.
- LDR/STR encoding: op=01, funct 011001 for LDR, 011000 for STR, src2=in_imm[11:0].
- B encoding: op=10, bits[25:24]=10, bits[23:0]=in_imm.
- Legal acceptance:
  - Registers the word and address.
  - Increments the address pointer and word_count.
- Illegal acceptance (class 5-7, or aluop 6-7 on a DP class):
  - Sets err.
  - No write; pointer and word_count unchanged.
  - in_last is still honoured.
- Overflow: a legal acceptance into address DEPTH-1 with in_last=0 ends the load (done pulses) and sets err.
- start:
  - Clears the pointer, word_count and err, then enters LOAD.
  - A write already registered from a prior acceptance still completes at its original address.

## Timing
- Reset value of every output: 0. State resets to IDLE.
- Latency: acceptance at edge N -> mem_we=1 with mem_addr/mem_wdata during cycle N+1, for exactly one cycle.
- Throughput: one word per cycle under continuous in_valid.
- done asserts in cycle N+1 after the terminating acceptance at edge N, coincident with the final write if that word is legal.
- in_ready is low in cycle N+1 because the state is IDLE.
- word_count updates at the acceptance edge.
- Reset mid-load: the pending write is dropped and mem_we is 0 immediately.

## Test plan
- Reset low mid-stream -> all outputs 0 asynchronously; in_ready stays 0 until start.
- start; DP-reg ADD, cond E, Rd1 Rn2 Rm3, S0, last -> mem_we at addr 0, data 0xE0821003; done the same cycle; word_count=1; err=0.
- DP-reg CMP, cond E, Rn4 Rm5, S0 supplied -> data 0xE1540005 (S and Rd forced).
- LDR Rd1 Rn0 imm 0x004 -> 0xE5901004; STR with the same fields -> 0xE5801004 at the next address; B cond E imm 0xFFFFFE -> 0xEAFFFFFE.
- ADDR_W=2, four legal words back-to-back with no last:
  - Writes at addresses 0..3 on consecutive cycles.
  - done with the fourth write; err=1; in_ready=0 afterwards; word_count=4.
- Illegal class 5 between two legal words -> err=1, no write; the legal words land at addresses 0 and 1. A following start clears err and word_count while the pending write completes.
